// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns PC and IR, fetches over a valid/ready request + valid response handshake.
// Optional macro FETCH_TIMEOUT_EN adds a response watchdog that aborts to a NOP and sets fetchErr.
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    INSTR_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0,
  parameter int                    TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   IRWrite,
  input  logic                   PCWrite,
  input  logic [ADDR_WIDTH-1:0]  nextPC,
  output logic                   imemReqValid,
  input  logic                   imemReqReady,
  output logic [ADDR_WIDTH-1:0]  imemAddr,
  input  logic                   imemRespValid,
  input  logic [INSTR_WIDTH-1:0] imemRespData,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [6:0]             opCode,
  output logic [2:0]             funct3,
  output logic [4:0]             rd,
  output logic [4:0]             rs1,
  output logic [4:0]             rs2,
  output logic                   fetchBusy,
  output logic                   fetchDone,
  output logic                   fetchErr
);

  localparam logic [INSTR_WIDTH-1:0] NOP         = INSTR_WIDTH'(32'h0000_0013);
  localparam logic [31:0]            TIMEOUT_VEC = 32'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t                 r_state, w_stateNext;
  logic [ADDR_WIDTH-1:0]  r_pc, w_pcNext;
  logic [ADDR_WIDTH-1:0]  r_addr, w_addrNext;
  logic [INSTR_WIDTH-1:0] r_instr, w_instrNext;
  logic                   r_reqValid, w_reqValidNext;
  logic                   r_busy, w_busyNext;
  logic                   r_done, w_doneNext;
  logic                   r_err, w_errNext;
  logic                   w_capture;
  logic                   w_unused;

`ifdef FETCH_TIMEOUT_EN
  localparam int            CW          = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT_CYCLES);
  logic [CW-1:0]            r_cnt, w_cntNext;
`endif

  // PC is word aligned, so the low bits of nextPC are intentionally dropped.
  assign w_unused = &{1'b0, nextPC[1:0], TIMEOUT_VEC[0]};

  always_comb begin
    w_stateNext    = r_state;
    w_pcNext       = PCWrite ? {nextPC[ADDR_WIDTH-1:2], 2'b00} : r_pc;
    w_addrNext     = r_addr;
    w_instrNext    = r_instr;
    w_reqValidNext = r_reqValid;
    w_busyNext     = r_busy;
    w_doneNext     = 1'b0;
    w_errNext      = r_err;
    w_capture      = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    w_cntNext      = r_cnt;
`endif
    case (r_state)
      IDLE: begin
        if (IRWrite) begin
          w_addrNext     = r_pc;
          w_reqValidNext = 1'b1;
          w_busyNext     = 1'b1;
          w_stateNext    = REQ;
`ifdef FETCH_TIMEOUT_EN
          w_cntNext      = '0;
`endif
        end
      end
      REQ: begin
        if (imemReqReady) begin
          w_reqValidNext = 1'b0;
          if (imemRespValid) w_capture = 1'b1;
          else               w_stateNext = WAIT;
        end
      end
      WAIT: begin
        if (imemRespValid) w_capture = 1'b1;
      end
      default: w_stateNext = IDLE;
    endcase

    if (w_capture) begin
      w_instrNext = imemRespData;
      w_doneNext  = 1'b1;
      w_busyNext  = 1'b0;
      w_stateNext = IDLE;
    end
`ifdef FETCH_TIMEOUT_EN
    // A response that arrives on the timeout cycle takes priority over the abort.
    else if (r_state != IDLE) begin
      w_cntNext = r_cnt + 1'b1;
      if (w_cntNext == TIMEOUT_VAL) begin
        w_instrNext    = NOP;
        w_errNext      = 1'b1;
        w_doneNext     = 1'b1;
        w_reqValidNext = 1'b0;
        w_busyNext     = 1'b0;
        w_stateNext    = IDLE;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_addr     <= RESET_PC;
      r_instr    <= NOP;
      r_reqValid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      r_cnt      <= '0;
`endif
    end else begin
      r_state    <= w_stateNext;
      r_pc       <= w_pcNext;
      r_addr     <= w_addrNext;
      r_instr    <= w_instrNext;
      r_reqValid <= w_reqValidNext;
      r_busy     <= w_busyNext;
      r_done     <= w_doneNext;
      r_err      <= w_errNext;
`ifdef FETCH_TIMEOUT_EN
      r_cnt      <= w_cntNext;
`endif
    end
  end

  assign imemReqValid = r_reqValid;
  assign imemAddr     = r_addr;
  assign pc           = r_pc;
  assign instr        = r_instr;
  assign opCode       = r_instr[6:0];
  assign rd           = r_instr[11:7];
  assign funct3       = r_instr[14:12];
  assign rs1          = r_instr[19:15];
  assign rs2          = r_instr[24:20];
  assign fetchBusy    = r_busy;
  assign fetchDone    = r_done;
  assign fetchErr     = r_err;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a memory model answers requests with random timing,
// expected requests/instructions are queued at issue and checked by independent processes.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          TIMEOUT_CYCLES = 16;

  logic        clk = 1'b0;
  logic        rst_n, IRWrite, PCWrite;
  logic [31:0] nextPC;
  logic        imemReqValid, imemReqReady;
  logic [31:0] imemAddr;
  logic        imemRespValid;
  logic [31:0] imemRespData;
  logic [31:0] pc, instr;
  logic [6:0]  opCode;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic        fetchBusy, fetchDone, fetchErr;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .IRWrite(IRWrite), .PCWrite(PCWrite), .nextPC(nextPC),
    .imemReqValid(imemReqValid), .imemReqReady(imemReqReady), .imemAddr(imemAddr),
    .imemRespValid(imemRespValid), .imemRespData(imemRespData),
    .pc(pc), .instr(instr), .opCode(opCode), .funct3(funct3), .rd(rd), .rs1(rs1), .rs2(rs2),
    .fetchBusy(fetchBusy), .fetchDone(fetchDone), .fetchErr(fetchErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  int          nCompared = 0;
  int          nMismatch = 0;
  logic [31:0] expAddrQ[$];
  exp_t        expQ[$];
  int          addrIdx = 0;
  int          rdIdx = 0;
  logic [31:0] modelPc;
  logic        modelErr;
  logic [31:0] lastInstr;
  int          cfgReadyDelay = 0, cfgRespDelay = 0;
  bit          cfgSame = 0, cfgHold = 0;
  int          pokeReq = 0, pokeAck = 0;
  logic [31:0] pokeData = '0;

  // Instruction memory contents as a pure function of address; address 0 holds add x3,x1,x2.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0) return 32'h0020_81B3;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F ^ {a[15:0], a[31:16]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory model: checks each request against the expected address and answers with configured timing.
  initial begin
    int memState, readyCnt, respCnt;
    logic [31:0] addrExp;
    memState = 0; readyCnt = 0; respCnt = 0; addrExp = '0;
    imemReqReady = 1'b0; imemRespValid = 1'b0; imemRespData = '0;
    forever begin
      @(negedge clk);
      imemReqReady = 1'b0; imemRespValid = 1'b0; imemRespData = '0;
      if (!rst_n) begin
        memState = 0;
      end else begin
        if (memState == 0 && imemReqValid) begin
          if (addrIdx < expAddrQ.size()) begin
            addrExp  = expAddrQ[addrIdx];
            addrIdx++;
            readyCnt = cfgReadyDelay;
            memState = 1;
          end else begin
            checkOutput("unexpectedReq", 32'(imemReqValid), 32'h0);
          end
        end
        if (memState == 1) begin
          checkOutput("reqValidHeld", 32'(imemReqValid), 32'h1);
          checkOutput("reqAddr", imemAddr, addrExp);
          if (readyCnt == 0) begin
            imemReqReady = 1'b1;
            if (cfgSame) begin
              imemRespValid = 1'b1; imemRespData = memWord(addrExp); memState = 0;
            end else if (cfgHold) begin
              memState = 3;
            end else begin
              respCnt = cfgRespDelay; memState = 2;
            end
          end else begin
            readyCnt--;
          end
        end else if (memState == 2) begin
          if (respCnt == 0) begin
            imemRespValid = 1'b1; imemRespData = memWord(addrExp); memState = 0;
          end else begin
            respCnt--;
          end
        end
        if (pokeReq != pokeAck && memState != 1 && memState != 2) begin
          imemRespValid = 1'b1; imemRespData = pokeData; pokeAck = pokeReq; memState = 0;
        end
      end
    end
  end

  // Monitor: every fetchDone pulse must match the next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && fetchDone) begin
        if (rdIdx >= expQ.size()) begin
          checkOutput("unexpectedDone", 32'(fetchDone), 32'h0);
        end else begin
          e = expQ[rdIdx];
          rdIdx++;
          checkOutput("instr", instr, e.instr);
          checkOutput("opCode", 32'(opCode), 32'(e.instr[6:0]));
          checkOutput("rd", 32'(rd), 32'(e.instr[11:7]));
          checkOutput("funct3", 32'(funct3), 32'(e.instr[14:12]));
          checkOutput("rs1", 32'(rs1), 32'(e.instr[19:15]));
          checkOutput("rs2", 32'(rs2), 32'(e.instr[24:20]));
          checkOutput("fetchErr", 32'(fetchErr), 32'(e.err));
          checkOutput("busyAtDone", 32'(fetchBusy), 32'h0);
        end
      end
    end
  end

  task automatic applyStimulus(input int rdy, input int rsp, input bit same,
                               input bit pcwNow, input logic [31:0] npcNow,
                               input bit midPcw, input logic [31:0] midNpc,
                               input bit midIrw, input string tag);
    int cyc;
    bit done;
    logic [31:0] w;
    @(negedge clk);
    cfgReadyDelay = rdy; cfgRespDelay = rsp; cfgSame = same; cfgHold = 0;
    w = memWord(modelPc);
    expAddrQ.push_back(modelPc);
    expQ.push_back('{w, modelErr});
    lastInstr = w;
    IRWrite = 1'b1;
    if (pcwNow) begin
      PCWrite = 1'b1; nextPC = npcNow; modelPc = npcNow & ~32'h3;
    end
    cyc = 0; done = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      IRWrite = 1'b0; PCWrite = 1'b0;
      cyc++;
      if (cyc == 3) begin
        if (midPcw) begin
          PCWrite = 1'b1; nextPC = midNpc; modelPc = midNpc & ~32'h3;
        end
        if (midIrw) IRWrite = 1'b1;
      end
      if (fetchDone) done = 1;
    end
    IRWrite = 1'b0; PCWrite = 1'b0;
    checkOutput({tag, "_latency"}, 32'(cyc), same ? 32'(2 + rdy) : 32'(3 + rdy + rsp));
    checkOutput({tag, "_busyAfter"}, 32'(fetchBusy), 32'h0);
  endtask

  task automatic writePc(input logic [31:0] v);
    @(negedge clk);
    PCWrite = 1'b1; nextPC = v; modelPc = v & ~32'h3;
    @(negedge clk);
    PCWrite = 1'b0;
    checkOutput("pcAfterWrite", pc, modelPc);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    rst_n = 1'b0; IRWrite = 1'b0; PCWrite = 1'b0; nextPC = '0;
    modelPc = '0; modelErr = 1'b0; lastInstr = NOP;
    repeat (3) @(negedge clk);
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_instr", instr, NOP);
    checkOutput("rst_reqValid", 32'(imemReqValid), 32'h0);
    checkOutput("rst_addr", imemAddr, 32'h0);
    checkOutput("rst_busy", 32'(fetchBusy), 32'h0);
    checkOutput("rst_done", 32'(fetchDone), 32'h0);
    checkOutput("rst_err", 32'(fetchErr), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(0, 0, 0, 0, '0, 0, '0, 0, "zeroWait");
    checkOutput("firstInstr", instr, 32'h0020_81B3);
    checkOutput("firstOpCode", 32'(opCode), 32'h33);
    checkOutput("firstRd", 32'(rd), 32'd3);
    checkOutput("firstRs1", 32'(rs1), 32'd1);
    checkOutput("firstRs2", 32'(rs2), 32'd2);
    checkOutput("firstAddr", imemAddr, 32'h0);
    @(negedge clk);
    checkOutput("donePulseOnce", 32'(fetchDone), 32'h0);

    writePc(32'h0000_0043);
    applyStimulus(5, 1, 0, 0, '0, 0, '0, 0, "readyStall");
    applyStimulus(0, 0, 1, 0, '0, 0, '0, 0, "sameCycle");

    writePc(32'h0000_0200);
    applyStimulus(0, 4, 0, 0, '0, 1, 32'h0000_0106, 0, "pcwInWait");
    checkOutput("pcAfterWaitWrite", pc, 32'h0000_0104);
    applyStimulus(0, 0, 0, 0, '0, 0, '0, 0, "fetchNewPc");

    applyStimulus(0, 4, 0, 0, '0, 0, '0, 1, "irwInWait");
    @(negedge clk);
    pokeData = 32'hDEAD_BEEF; pokeReq++;
    repeat (3) @(negedge clk);
    checkOutput("irAfterSpurious", instr, lastInstr);
    checkOutput("busyAfterSpurious", 32'(fetchBusy), 32'h0);
    checkOutput("reqAfterSpurious", 32'(imemReqValid), 32'h0);

    applyStimulus(1, 1, 0, 1, 32'h0000_0ABF, 0, '0, 0, "pcwIrwSame");
    checkOutput("pcAfterSameCycle", pc, 32'h0000_0ABC);

    for (int i = 0; i < 24; i++) begin
      applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom, 0, '0, 0, "random");
    end
    checkOutput("pcAfterRandom", pc, modelPc);

    // Reset while waiting for a response; the late response must be ignored.
    @(negedge clk);
    cfgHold = 1; cfgSame = 0; cfgReadyDelay = 0;
    expAddrQ.push_back(modelPc);
    IRWrite = 1'b1;
    @(negedge clk);
    IRWrite = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("busyBeforeReset", 32'(fetchBusy), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midRst_pc", pc, 32'h0);
    checkOutput("midRst_instr", instr, NOP);
    checkOutput("midRst_busy", 32'(fetchBusy), 32'h0);
    checkOutput("midRst_reqValid", 32'(imemReqValid), 32'h0);
    rst_n = 1'b1;
    modelPc = '0; modelErr = 1'b0; lastInstr = NOP;
    @(negedge clk);
    pokeData = 32'h00A0_0093; pokeReq++;
    repeat (3) @(negedge clk);
    checkOutput("irAfterLateResp", instr, NOP);
    checkOutput("busyAfterLateResp", 32'(fetchBusy), 32'h0);

    @(negedge clk);
    cfgHold = 1; cfgSame = 0; cfgReadyDelay = 0;
    expAddrQ.push_back(modelPc);
`ifdef FETCH_TIMEOUT_EN
    expQ.push_back('{NOP, 1'b1});
    modelErr = 1'b1; lastInstr = NOP;
    IRWrite = 1'b1;
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      IRWrite = 1'b0;
      cyc++;
      if (fetchDone) break;
    end
    checkOutput("timeoutLatency", 32'(cyc), 32'(TIMEOUT_CYCLES + 1));
    checkOutput("timeoutErr", 32'(fetchErr), 32'h1);
    checkOutput("timeoutInstr", instr, NOP);
    checkOutput("timeoutBusy", 32'(fetchBusy), 32'h0);
    checkOutput("timeoutReqValid", 32'(imemReqValid), 32'h0);
    pokeData = 32'h0000_0000; pokeReq++;
    repeat (2) @(negedge clk);
    applyStimulus(0, 0, 0, 0, '0, 0, '0, 0, "afterTimeout");
    checkOutput("errSticky", 32'(fetchErr), 32'h1);
`else
    IRWrite = 1'b1;
    @(negedge clk);
    IRWrite = 1'b0;
    cyc = 0;
    repeat (40) @(negedge clk);
    checkOutput("holdBusy", 32'(fetchBusy), 32'h1);
    checkOutput("holdErr", 32'(fetchErr), 32'h0);
    checkOutput("holdReqValid", 32'(imemReqValid), 32'h0);
    checkOutput("holdInstr", instr, NOP);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
